data_mem_unit: RTL

- Memory-side responder for the LDW (op 6'b001100) and STW (op 6'b001101) instructions.
- The ALU computes the effective address A = rs + imm. This block accepts that address, the opcode and the store data (rt) over a valid/ready request channel.
- It performs the word access on an internal array with a fixed, parameterised latency. It then returns load data or a store acknowledge over a valid/ready response channel.
- It sits between the execute stage and writeback.

---
 rtl/data_mem_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_mem_unit.sv
// Memory-side responder for LDW/STW: accepts an effective address over a
// valid/ready request channel, accesses an internal word array after a fixed
// latency and returns load data or a store acknowledge on a response channel.
module data_mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [5:0]           req_op,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [5:0] OP_LDW = 6'b001100;
    localparam logic [5:0] OP_STW = 6'b001101;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                is_store;
    logic [31:0]         wdata_q;
    logic [31:0]         mem [DEPTH_WORDS];

    logic                accept;
    logic                op_ok;
    logic                aligned;
    logic                in_range;
    logic                req_bad;
    logic                commit;

    // Classification looks only at the word index; no wrap-around above the array.
    always_comb begin
        accept   = req_valid && (state == IDLE);
        op_ok    = (req_op == OP_LDW) || (req_op == OP_STW);
        aligned  = (req_addr[1:0] == 2'b00);
        in_range = ({2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS));
        req_bad  = !(op_ok && aligned && in_range);
        commit   = (state == ACCESS) && (cnt == '0);
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
            cnt       <= '0;
            idx       <= '0;
            is_store  <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            if (err_count != '1)
                                err_count <= err_count + 1'b1;
                        end else begin
                            state    <= ACCESS;
                            cnt      <= CNT_W'(RD_LATENCY - 1);
                            idx      <= req_addr[IDX_W+1:2];
                            is_store <= (req_op == OP_STW);
                            wdata_q  <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= is_store ? 32'h0 : mem[idx];
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stores land only on the ACCESS->RESP edge; reset forces IDLE so a pending store is dropped.
    always_ff @(posedge clk) begin
        if (commit && is_store)
            mem[idx] <= wdata_q;
    end

endmodule
